// File: rtl/sw_pkg.sv
// sw_pkg: shared types and constants for the slide-switch debouncer.
//   db_state_t     - per-bit debounce FSM state
//   DEBOUNCE_SIM   - stable-cycle count used in simulation
//   DEBOUNCE_BOARD - stable-cycle count used on the board (10 ms at 50 MHz)
package sw_pkg;

  typedef enum logic {STABLE, PENDING} db_state_t;

  localparam int DEBOUNCE_SIM   = 16;
  localparam int DEBOUNCE_BOARD = 500000;

endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: two-flop synchronizer plus debounce FSM for one switch bit.
// Ports:
//   clk    - system clock
//   rst_b  - synchronous active-low reset
//   raw    - asynchronous switch level
//   stable - debounced level (registered)
//   commit - high in the cycle the debounced level toggles (it toggles on the
//            next rising edge)
//
// state   | meaning
// --------+-----------------------------------------------------------
// STABLE  | synchronized input matches stable, counter idle at 0
// PENDING | input differs from stable, counting consecutive cycles
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic clk,
  input  logic rst_b,
  input  logic raw,
  output logic stable,
  output logic commit
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stable_nxt;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      state  <= STABLE;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      stable <= stable_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stable_nxt = stable;
    commit     = 1'b0;
    case (state)
      STABLE: begin
        cnt_nxt = '0;
        if (sync2 != stable) begin
          state_nxt = PENDING;
          cnt_nxt   = CNT_W'(1);
        end
      end
      PENDING: begin
        if (sync2 == stable) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          // terminal count reached: the counter never needs to wrap
          state_nxt  = STABLE;
          cnt_nxt    = '0;
          stable_nxt = ~stable;
          commit     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/sw_debouncer.sv
// sw_debouncer: synchronizes and debounces a slide-switch bus and raises a
// coalescing change event with a valid/ready handshake.
// Ports:
//   clk       - system clock
//   KEY0      - synchronous active-low reset
//   SW        - raw asynchronous switch levels
//   sw_stable - debounced switch value
//   evt_valid - a change event is pending
//   evt_data  - sw_stable value at the most recent commit
//   evt_mask  - bits committed since the last accepted event
//   evt_ready - consumer accepts the event
module sw_debouncer
  import sw_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic             clk,
  input  logic             KEY0,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] sw_stable,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  output logic [WIDTH-1:0] evt_mask,
  input  logic             evt_ready
);

  logic [WIDTH-1:0] commit;
  logic [WIDTH-1:0] stable_nxt;
  logic             any_commit;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk   (clk),
        .rst_b (KEY0),
        .raw   (SW[i]),
        .stable(sw_stable[i]),
        .commit(commit[i])
      );
    end
  endgenerate

  // a committing bit toggles, so the post-edge stable value is a simple xor
  assign stable_nxt = sw_stable ^ commit;
  assign any_commit = |commit;

  always_ff @(posedge clk) begin
    if (!KEY0) begin
      evt_valid <= 1'b0;
      evt_data  <= '0;
      evt_mask  <= '0;
    end else if (any_commit) begin
      evt_valid <= 1'b1;
      evt_data  <= stable_nxt;
      // an accept on this edge retires the old event, so start a fresh mask
      if (!evt_valid || evt_ready) begin
        evt_mask <= commit;
      end else begin
        evt_mask <= evt_mask | commit;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sw_debouncer.sv
module tb_sw_debouncer;

  localparam int W = 10;

  typedef struct packed {
    logic [W-1:0] data;
    logic [W-1:0] mask;
  } evt_t;

  logic         clk;
  logic         KEY0;
  logic [W-1:0] SW;
  logic [W-1:0] sw_stable;
  logic         evt_valid;
  logic [W-1:0] evt_data;
  logic [W-1:0] evt_mask;
  logic         evt_ready;

  int   n_checks;
  int   n_fail;
  bit   mon_en;
  evt_t exp_q[$];

  sw_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk      (clk),
    .KEY0     (KEY0),
    .SW       (SW),
    .sw_stable(sw_stable),
    .evt_valid(evt_valid),
    .evt_data (evt_data),
    .evt_mask (evt_mask),
    .evt_ready(evt_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // inputs change 1 time unit after each falling edge
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    KEY0 = 1'b0;
    SW   = '0;
    step(1);
    KEY0 = 1'b1;
  endtask

  task automatic expect_evt(input logic [W-1:0] data, input logic [W-1:0] mask);
    evt_t e;
    e.data = data;
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  // monitor: every handshake on the coming rising edge must match the oldest
  // queued expectation
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && evt_valid === 1'b1 && evt_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_evt: got data 0x%0h mask 0x%0h, want no event at %0t",
                   evt_data, evt_mask, $time);
        end else begin
          evt_t e;
          e = exp_q.pop_front();
          check("evt_data", 32'(evt_data), 32'(e.data));
          check("evt_mask", 32'(evt_mask), 32'(e.mask));
        end
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    mon_en    = 1'b0;
    KEY0      = 1'b0;
    SW        = '0;
    evt_ready = 1'b1;

    // reset, idle
    step(2);
    check("rst_stable", 32'(sw_stable), 32'h0);
    check("rst_valid", 32'(evt_valid), 32'h0);
    check("rst_data", 32'(evt_data), 32'h0);
    check("rst_mask", 32'(evt_mask), 32'h0);
    KEY0   = 1'b1;
    mon_en = 1'b1;
    step(40);
    check("idle_stable", 32'(sw_stable), 32'h0);
    check("idle_valid", 32'(evt_valid), 32'h0);

    // steady change, immediate accept
    SW = 10'h155;
    expect_evt(10'h155, 10'h155);
    step(17);
    check("steady_not_early", 32'(sw_stable), 32'h0);
    step(1);
    check("steady_stable", 32'(sw_stable), 32'h155);
    check("steady_valid", 32'(evt_valid), 32'h1);
    step(1);
    check("steady_pulse_1cyc", 32'(evt_valid), 32'h0);

    // glitch reject
    do_reset();
    SW = 10'h001;
    step(10);
    SW = 10'h000;
    step(30);
    check("glitch_stable", 32'(sw_stable), 32'h0);
    check("glitch_valid", 32'(evt_valid), 32'h0);

    // bounce on bit3, then settle high
    do_reset();
    for (int i = 0; i < 10; i++) begin
      SW = SW ^ 10'h008;
      step(3);
    end
    check("bounce_mid_stable", 32'(sw_stable), 32'h0);
    SW = 10'h008;
    expect_evt(10'h008, 10'h008);
    step(17);
    check("bounce_not_early", 32'(sw_stable), 32'h0);
    step(1);
    check("bounce_stable", 32'(sw_stable), 32'h008);
    step(2);

    // coalesce with consumer stalled
    do_reset();
    evt_ready = 1'b0;
    SW = 10'h001;
    expect_evt(10'h003, 10'h003);
    step(18);
    check("coal_b0_stable", 32'(sw_stable), 32'h001);
    check("coal_b0_valid", 32'(evt_valid), 32'h1);
    check("coal_b0_mask", 32'(evt_mask), 32'h001);
    SW = 10'h003;
    step(18);
    check("coal_stable", 32'(sw_stable), 32'h003);
    check("coal_valid", 32'(evt_valid), 32'h1);
    check("coal_data", 32'(evt_data), 32'h003);
    check("coal_mask", 32'(evt_mask), 32'h003);
    evt_ready = 1'b1;
    step(1);
    check("coal_accept_clears", 32'(evt_valid), 32'h0);
    evt_ready = 1'b0;

    // accept and new commit on the same edge
    SW = 10'h007;
    expect_evt(10'h007, 10'h004);
    step(3);
    SW = 10'h00F;
    expect_evt(10'h00F, 10'h008);
    step(17);
    check("same_edge_pending_mask", 32'(evt_mask), 32'h004);
    check("same_edge_pending_valid", 32'(evt_valid), 32'h1);
    evt_ready = 1'b1;
    step(1);
    check("same_edge_valid", 32'(evt_valid), 32'h1);
    check("same_edge_data", 32'(evt_data), 32'h00F);
    check("same_edge_mask", 32'(evt_mask), 32'h008);
    step(1);
    check("same_edge_done", 32'(evt_valid), 32'h0);

    // reset in the middle of a count
    SW = 10'h200;
    step(8);
    KEY0 = 1'b0;
    step(1);
    check("midrst_stable", 32'(sw_stable), 32'h0);
    check("midrst_valid", 32'(evt_valid), 32'h0);
    check("midrst_data", 32'(evt_data), 32'h0);
    check("midrst_mask", 32'(evt_mask), 32'h0);
    KEY0 = 1'b1;
    expect_evt(10'h200, 10'h200);
    step(17);
    check("midrst_not_early", 32'(sw_stable), 32'h0);
    step(1);
    check("midrst_stable_commit", 32'(sw_stable), 32'h200);
    step(3);

    check("events_outstanding", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
